// File: rtl/sdram_frame_seq.sv
// sdram_frame_seq: SDRAM frame-buffer burst sequencer for the camera-to-monitor path
// (clk_133M domain, beside sdram_top). Issues one line-sized burst at a time. Writes
// drain the ingest FIFO and reads fill the display FIFO. Reads win arbitration, and
// the reader restarts on every vsync frame.
//
// Optional feature macro: PINGPONG_EN. When it is defined, frames are double-buffered
// (buffer select on address bit BUF_BIT). When it is not defined, the block captures
// one frame into a single buffer and replays it on every frame.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   vsync                 1 = active frame, 0 = blanking (reader restart)
//   wr_fifo_used          ingest FIFO fill level
//   rd_fifo_used          display FIFO fill level
//   wr_sdram_req/ack/add  write burst handshake and address
//   rd_sdram_req/ack/add  read burst handshake and address
//   wr_frame_done         sticky, set once a full frame has been written
//   wr_line / rd_line     next line to write / read
//   busy                  a request is outstanding
//
// rd_line carries the low LINE_W bits of an internal LINE_W+1 bit read counter. That
// counter saturates at LINES, which stops further reads within the frame. When
// LINES = 2^LINE_W, the rd_line output therefore reads 0 once the frame is fully read.
module sdram_frame_seq #(
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned ROW_LSB   = 9,
  parameter int unsigned LINE_W    = 7,
  parameter int unsigned LINES     = 128,
  parameter int unsigned CNT_W     = 11,
  parameter int unsigned WR_THRESH = 512,
  parameter int unsigned RD_THRESH = 512,
  parameter int unsigned BUF_BIT   = 21
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vsync,
  input  logic [CNT_W-1:0]  wr_fifo_used,
  input  logic [CNT_W-1:0]  rd_fifo_used,
  output logic              wr_sdram_req,
  input  logic              wr_sdram_ack,
  output logic [ADDR_W-1:0] wr_sdram_add,
  output logic              rd_sdram_req,
  input  logic              rd_sdram_ack,
  output logic [ADDR_W-1:0] rd_sdram_add,
  output logic              wr_frame_done,
  output logic [LINE_W-1:0] wr_line,
  output logic [LINE_W-1:0] rd_line,
  output logic              busy
);

  localparam int unsigned RCNT_W = LINE_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_t;

  state_t              state, state_d;
  logic                wr_req_d, rd_req_d;
  logic [ADDR_W-1:0]   wr_add_d, rd_add_d;
  logic                done_d;
  logic [LINE_W-1:0]   wr_line_d;
  logic [RCNT_W-1:0]   rd_cnt, rd_cnt_d;
  logic                busy_d;
  logic                pend_rd_rst, pend_d;
  logic                wr_buf, rd_buf;
  logic                wr_block, wr_elig, rd_elig;

`ifdef PINGPONG_EN
  logic wr_buf_d, rd_buf_d, last_full, last_full_d, vsync_q;
`else
  assign wr_buf = 1'b0;
  assign rd_buf = 1'b0;
`endif

  // Burst address: the line field sits at ROW_LSB, the buffer select sits at BUF_BIT,
  // and the column bits are 0.
  function automatic logic [ADDR_W-1:0] make_addr(input logic [LINE_W-1:0] line,
                                                  input logic b);
    make_addr = (ADDR_W'(line) << ROW_LSB) | (ADDR_W'(b) << BUF_BIT);
  endfunction

  assign rd_line = rd_cnt[LINE_W-1:0];

  // Single buffer: capture once. Double buffer: never write into the frame on display.
`ifdef PINGPONG_EN
  assign wr_block = (wr_buf == rd_buf) && vsync && wr_frame_done;
`else
  assign wr_block = wr_frame_done;
`endif

  assign wr_elig = (wr_fifo_used >= CNT_W'(WR_THRESH)) && !wr_block;
  assign rd_elig = vsync && wr_frame_done && (rd_fifo_used <= CNT_W'(RD_THRESH)) &&
                   (rd_cnt < RCNT_W'(LINES));

  // Next-state and next-output logic
  always_comb begin
    state_d   = state;
    wr_req_d  = wr_sdram_req;
    rd_req_d  = rd_sdram_req;
    done_d    = wr_frame_done;
    wr_line_d = wr_line;
    rd_cnt_d  = rd_cnt;
    pend_d    = pend_rd_rst;
`ifdef PINGPONG_EN
    wr_buf_d    = wr_buf;
    last_full_d = last_full;
    rd_buf_d    = rd_buf;
    // The display latches the most recently completed frame at the start of a frame.
    if (vsync && !vsync_q) rd_buf_d = last_full;
`endif

    case (state)
      IDLE: begin
        if (!vsync) rd_cnt_d = '0;
        if (rd_elig) begin
          state_d  = RD;
          rd_req_d = 1'b1;
        end else if (wr_elig) begin
          state_d  = WR;
          wr_req_d = 1'b1;
        end
      end
      WR: begin
        if (!vsync) rd_cnt_d = '0;
        if (wr_sdram_ack) begin
          state_d  = IDLE;
          wr_req_d = 1'b0;
          if (wr_line == LINE_W'(LINES - 1)) begin
            wr_line_d = '0;
            done_d    = 1'b1;
`ifdef PINGPONG_EN
            last_full_d = wr_buf;
            wr_buf_d    = ~wr_buf;
`endif
          end else begin
            wr_line_d = wr_line + LINE_W'(1);
          end
        end
      end
      RD: begin
        // A read in flight is never withdrawn, so a blanking restart is deferred to its ack.
        if (!vsync) pend_d = 1'b1;
        if (rd_sdram_ack) begin
          state_d  = IDLE;
          rd_req_d = 1'b0;
          pend_d   = 1'b0;
          if (pend_rd_rst || !vsync) rd_cnt_d = '0;
          else if (rd_cnt < RCNT_W'(LINES)) rd_cnt_d = rd_cnt + RCNT_W'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        wr_req_d = 1'b0;
        rd_req_d = 1'b0;
      end
    endcase

`ifdef PINGPONG_EN
    wr_add_d = make_addr(wr_line_d, wr_buf_d);
    rd_add_d = make_addr(rd_cnt_d[LINE_W-1:0], rd_buf_d);
`else
    wr_add_d = make_addr(wr_line_d, wr_buf);
    rd_add_d = make_addr(rd_cnt_d[LINE_W-1:0], rd_buf);
`endif
    // Keep the read address frozen while its request is up (a buffer swap may land mid-burst).
    if (state == RD && !rd_sdram_ack) rd_add_d = rd_sdram_add;
    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      wr_sdram_req  <= 1'b0;
      rd_sdram_req  <= 1'b0;
      wr_sdram_add  <= '0;
      rd_sdram_add  <= '0;
      wr_frame_done <= 1'b0;
      wr_line       <= '0;
      rd_cnt        <= '0;
      busy          <= 1'b0;
      pend_rd_rst   <= 1'b0;
    end else begin
      state         <= state_d;
      wr_sdram_req  <= wr_req_d;
      rd_sdram_req  <= rd_req_d;
      wr_sdram_add  <= wr_add_d;
      rd_sdram_add  <= rd_add_d;
      wr_frame_done <= done_d;
      wr_line       <= wr_line_d;
      rd_cnt        <= rd_cnt_d;
      busy          <= busy_d;
      pend_rd_rst   <= pend_d;
    end
  end

`ifdef PINGPONG_EN
  // Frame buffer selection registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_buf    <= 1'b0;
      rd_buf    <= 1'b0;
      last_full <= 1'b0;
      vsync_q   <= 1'b0;
    end else begin
      wr_buf    <= wr_buf_d;
      rd_buf    <= rd_buf_d;
      last_full <= last_full_d;
      vsync_q   <= vsync;
    end
  end
`endif

endmodule

// File: tb/tb_sdram_frame_seq.sv
// Directed bench for sdram_frame_seq: frame capture, frame replay, the vsync restart
// of an in-flight read, and reset during a write. When PINGPONG_EN is defined, it also
// covers double buffering and read-over-write priority.
module tb_sdram_frame_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vsync;
  logic [10:0] wr_fifo_used, rd_fifo_used;
  logic        wr_sdram_req, wr_sdram_ack, rd_sdram_req, rd_sdram_ack;
  logic [23:0] wr_sdram_add, rd_sdram_add;
  logic        wr_frame_done, busy;
  logic [6:0]  wr_line, rd_line;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sdram_frame_seq dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .vsync         (vsync),
    .wr_fifo_used  (wr_fifo_used),
    .rd_fifo_used  (rd_fifo_used),
    .wr_sdram_req  (wr_sdram_req),
    .wr_sdram_ack  (wr_sdram_ack),
    .wr_sdram_add  (wr_sdram_add),
    .rd_sdram_req  (rd_sdram_req),
    .rd_sdram_ack  (rd_sdram_ack),
    .rd_sdram_add  (rd_sdram_add),
    .wr_frame_done (wr_frame_done),
    .wr_line       (wr_line),
    .rd_line       (rd_line),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One write burst: wait for req, check address, ack after `gap` further cycles.
  task automatic wr_burst(input logic [23:0] exp_add, input int gap);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (wr_sdram_req) got = 1'b1;
      else tick();
    end
    check("wr_req_seen", 32'(got), 32'd1);
    check("wr_add", 32'(wr_sdram_add), 32'(exp_add));
    repeat (gap) tick();
    check("wr_req_held", 32'(wr_sdram_req), 32'd1);
    wr_sdram_ack = 1'b1;
    tick();
    wr_sdram_ack = 1'b0;
    check("wr_req_drop", 32'(wr_sdram_req), 32'd0);
  endtask

  task automatic rd_burst(input logic [23:0] exp_add, input int gap);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (rd_sdram_req) got = 1'b1;
      else tick();
    end
    check("rd_req_seen", 32'(got), 32'd1);
    check("rd_add", 32'(rd_sdram_add), 32'(exp_add));
    repeat (gap) tick();
    rd_sdram_ack = 1'b1;
    tick();
    rd_sdram_ack = 1'b0;
    check("rd_req_drop", 32'(rd_sdram_req), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst_n = 1'b0; vsync = 1'b0; wr_fifo_used = '0; rd_fifo_used = 11'd1000;
    wr_sdram_ack = 1'b0; rd_sdram_ack = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_wr_req", 32'(wr_sdram_req), 32'd0);
    check("rst_rd_req", 32'(rd_sdram_req), 32'd0);
    check("rst_wr_add", 32'(wr_sdram_add), 32'd0);
    check("rst_rd_add", 32'(rd_sdram_add), 32'd0);
    check("rst_done", 32'(wr_frame_done), 32'd0);
    check("rst_wr_line", 32'(wr_line), 32'd0);
    check("rst_rd_line", 32'(rd_line), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();

`ifndef PINGPONG_EN
    // Capture one frame: 128 write bursts at line<<9
    wr_fifo_used = 11'd600;
    for (int l = 0; l < 128; l++) begin
      wr_burst(24'(l << 9), 3);
      check("wr_line_next", 32'(wr_line), 32'((l + 1) % 128));
      check("wr_done", 32'(wr_frame_done), (l == 127) ? 32'd1 : 32'd0);
    end
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (wr_sdram_req || rd_sdram_req) seen = 1'b1;
    end
    check("no_129th_req", 32'(seen), 32'd0);

    // Replay: 128 reads, then saturate with no further request
    vsync = 1'b1; rd_fifo_used = 11'd100;
    for (int l = 0; l < 128; l++) begin
      rd_burst(24'(l << 9), 2);
      if (l < 127) check("rd_line_next", 32'(rd_line), 32'(l + 1));
    end
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (wr_sdram_req || rd_sdram_req) seen = 1'b1;
    end
    check("rd_saturated_no_req", 32'(seen), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);

    // Blanking restarts the reader, including a read caught in flight
    vsync = 1'b0;
    tick();
    check("blank_rd_line", 32'(rd_line), 32'd0);
    vsync = 1'b1;
    rd_burst(24'h000000, 1);
    rd_burst(24'h000200, 1);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (rd_sdram_req) seen = 1'b1;
      else tick();
    end
    check("inflight_req_seen", 32'(seen), 32'd1);
    check("inflight_add", 32'(rd_sdram_add), 32'h400);
    vsync = 1'b0;
    tick(); tick(); tick();
    check("inflight_held", 32'(rd_sdram_req), 32'd1);
    check("inflight_add_stable", 32'(rd_sdram_add), 32'h400);
    check("inflight_busy", 32'(busy), 32'd1);
    rd_sdram_ack = 1'b1;
    tick();
    rd_sdram_ack = 1'b0;
    check("inflight_drop", 32'(rd_sdram_req), 32'd0);
    check("inflight_rd_line", 32'(rd_line), 32'd0);
    tick(); tick();
    vsync = 1'b1;
    rd_burst(24'h000000, 1);
    check("restart_rd_line", 32'(rd_line), 32'd1);
`else
    // Frame 0 into buffer 0
    wr_fifo_used = 11'd600;
    for (int l = 0; l < 128; l++) wr_burst(24'(l << 9), 3);
    wr_fifo_used = '0;
    check("pp_done", 32'(wr_frame_done), 32'd1);
    vsync = 1'b1;
    tick();
    // Frame 1 into buffer 1 while buffer 0 is displayed
    wr_fifo_used = 11'd600;
    for (int l = 0; l < 128; l++) wr_burst(24'((1 << 21) | (l << 9)), 2);
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (wr_sdram_req) seen = 1'b1;
    end
    check("pp_stall", 32'(seen), 32'd0);
    // Blanking, then next frame: display buffer 1, write buffer 0, read wins
    wr_fifo_used = '0;
    vsync = 1'b0;
    tick(); tick();
    vsync = 1'b1;
    tick();
    wr_fifo_used = 11'd600; rd_fifo_used = '0;
    tick();
    check("pp_rd_first", 32'(rd_sdram_req), 32'd1);
    check("pp_wr_wait", 32'(wr_sdram_req), 32'd0);
    check("pp_rd_add", 32'(rd_sdram_add), 32'h200000);
    tick(); tick();
    rd_sdram_ack = 1'b1; rd_fifo_used = 11'd1000;
    tick();
    rd_sdram_ack = 1'b0;
    check("pp_ack_no_wr", 32'(wr_sdram_req), 32'd0);
    check("pp_rd_line", 32'(rd_line), 32'd1);
    tick();
    check("pp_wr_after_idle", 32'(wr_sdram_req), 32'd1);
    check("pp_wr_add", 32'(wr_sdram_add), 32'h000000);
    wr_sdram_ack = 1'b1;
    tick();
    wr_sdram_ack = 1'b0;
`endif

    // Reset in the middle of a write burst
    rst_n = 1'b0;
    tick();
    check("rst2_done", 32'(wr_frame_done), 32'd0);
    check("rst2_rd_line", 32'(rd_line), 32'd0);
    rst_n = 1'b1; vsync = 1'b0; rd_fifo_used = 11'd1000; wr_fifo_used = 11'd600;
    tick();
    for (int l = 0; l < 3; l++) wr_burst(24'(l << 9), 3);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (wr_sdram_req) seen = 1'b1;
      else tick();
    end
    check("midwr_req_seen", 32'(seen), 32'd1);
    check("midwr_add", 32'(wr_sdram_add), 32'h600);
    check("midwr_line", 32'(wr_line), 32'd3);
    rst_n = 1'b0;
    tick();
    check("midwr_req_drop", 32'(wr_sdram_req), 32'd0);
    check("midwr_line_clr", 32'(wr_line), 32'd0);
    check("midwr_done_clr", 32'(wr_frame_done), 32'd0);
    check("midwr_busy_clr", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
